// File: rtl/branch_resolve_pipe_pkg.sv
// Shared definitions for the pipelined branch resolver.
//   BR_OP_W : width of the branch-condition opcode.
//   br_op_e : branch-condition encodings, EQ through LTU.
package branch_resolve_pipe_pkg;

    localparam int BR_OP_W = 3;

    typedef enum logic [BR_OP_W-1:0] {
        BR_EQ  = 3'd0,  // rs == rt
        BR_NE  = 3'd1,  // rs != rt
        BR_LTZ = 3'd2,  // rs <  0 (signed)
        BR_LEZ = 3'd3,  // rs <= 0 (signed)
        BR_GTZ = 3'd4,  // rs >  0 (signed)
        BR_GEZ = 3'd5,  // rs >= 0 (signed)
        BR_LT  = 3'd6,  // rs <  rt (signed)
        BR_LTU = 3'd7   // rs <  rt (unsigned)
    } br_op_e;

endpackage

// File: rtl/branch_resolve_pipe_cond.sv
// branch_cond_eval: purely combinational branch-condition evaluator.
// Ports:
//   op    : condition select (br_op_e encoding)
//   rs    : first operand
//   rt    : second operand, only used by EQ/NE/LT/LTU
//   taken : resolved outcome
module branch_cond_eval
    import branch_resolve_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [BR_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    output logic               taken
);

    logic eq;
    logic rs_neg;
    logic rs_zero;
    logic lt_s;
    logic lt_u;

    assign eq      = (rs == rt);
    assign rs_neg  = rs[WIDTH-1];
    assign rs_zero = (rs == '0);
    assign lt_s    = ($signed(rs) < $signed(rt));
    assign lt_u    = (rs < rt);

    always_comb begin
        taken = 1'b0;
        case (br_op_e'(op))
            BR_EQ:  taken = eq;
            BR_NE:  taken = !eq;
            BR_LTZ: taken = rs_neg;
            BR_LEZ: taken = rs_neg || rs_zero;
            BR_GTZ: taken = !rs_neg && !rs_zero;
            BR_GEZ: taken = !rs_neg;
            BR_LT:  taken = lt_s;
            BR_LTU: taken = lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_pipe.sv
// branch_resolve_pipe: two-stage branch resolver with mispredict detection.
// S1 registers the request, the condition is evaluated from S1, and S2 holds
// the result until the consumer takes it.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   flush                  : drop everything in flight on the next edge
//   in_valid/in_ready      : request handshake (in_op, in_rs, in_rt, in_pred, in_tag)
//   out_valid/out_ready    : result handshake (out_taken, out_mispredict, out_tag)
//   cnt_clr                : synchronous clear of both statistics counters
//   br_cnt, mis_cnt        : saturating counts of delivered branches / mispredicts
// Handshake: a transfer happens on a rising edge where valid && ready. A stage
// that holds data keeps it unchanged until its downstream transfer completes;
// in_ready is a function of pipeline state and out_ready only, never in_valid.
module branch_resolve_pipe
    import branch_resolve_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 8,
    parameter int CNTW  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BR_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]   in_rs,
    input  logic [WIDTH-1:0]   in_rt,
    input  logic               in_pred,
    input  logic [TAGW-1:0]    in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_taken,
    output logic               out_mispredict,
    output logic [TAGW-1:0]    out_tag,
    input  logic               cnt_clr,
    output logic [CNTW-1:0]    br_cnt,
    output logic [CNTW-1:0]    mis_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // Stage 1: registered request
    logic               s1_valid_q, s1_valid_d;
    logic [BR_OP_W-1:0] s1_op_q,    s1_op_d;
    logic [WIDTH-1:0]   s1_rs_q,    s1_rs_d;
    logic [WIDTH-1:0]   s1_rt_q,    s1_rt_d;
    logic               s1_pred_q,  s1_pred_d;
    logic [TAGW-1:0]    s1_tag_q,   s1_tag_d;

    // Stage 2: registered result
    logic               s2_valid_q, s2_valid_d;
    logic               s2_taken_q, s2_taken_d;
    logic               s2_mis_q,   s2_mis_d;
    logic [TAGW-1:0]    s2_tag_q,   s2_tag_d;

    logic [CNTW-1:0]    br_cnt_q,   br_cnt_d;
    logic [CNTW-1:0]    mis_cnt_q,  mis_cnt_d;

    logic s1_taken;
    logic s2_adv;
    logic out_fire;

    branch_cond_eval #(.WIDTH(WIDTH)) u_cond (
        .op    (s1_op_q),
        .rs    (s1_rs_q),
        .rt    (s1_rt_q),
        .taken (s1_taken)
    );

    assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_adv;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_rs_d    = s1_rs_q;
        s1_rt_d    = s1_rt_q;
        s1_pred_d  = s1_pred_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_taken_d = s2_taken_q;
        s2_mis_d   = s2_mis_q;
        s2_tag_d   = s2_tag_q;
        br_cnt_d   = br_cnt_q;
        mis_cnt_d  = mis_cnt_q;

        // S1 either refills from the input or drains empty whenever it can move.
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d   = in_op;
                s1_rs_d   = in_rs;
                s1_rt_d   = in_rt;
                s1_pred_d = in_pred;
                s1_tag_d  = in_tag;
            end
        end

        if (s2_adv) begin
            s2_valid_d = 1'b1;
            s2_taken_d = s1_taken;
            s2_mis_d   = s1_taken ^ s1_pred_q;
            s2_tag_d   = s1_tag_q;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end

        // Flush only kills valids; a result leaving in the flush cycle still counts.
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end

        if (out_fire) begin
            if (br_cnt_q != CNT_MAX) begin
                br_cnt_d = br_cnt_q + CNT_ONE;
            end
            if (s2_mis_q && (mis_cnt_q != CNT_MAX)) begin
                mis_cnt_d = mis_cnt_q + CNT_ONE;
            end
        end

        if (cnt_clr) begin
            br_cnt_d  = '0;
            mis_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_rs_q    <= '0;
            s1_rt_q    <= '0;
            s1_pred_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_taken_q <= 1'b0;
            s2_mis_q   <= 1'b0;
            s2_tag_q   <= '0;
            br_cnt_q   <= '0;
            mis_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_rs_q    <= s1_rs_d;
            s1_rt_q    <= s1_rt_d;
            s1_pred_q  <= s1_pred_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_taken_q <= s2_taken_d;
            s2_mis_q   <= s2_mis_d;
            s2_tag_q   <= s2_tag_d;
            br_cnt_q   <= br_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_taken      = s2_taken_q;
    assign out_mispredict = s2_mis_q;
    assign out_tag        = s2_tag_q;
    assign br_cnt         = br_cnt_q;
    assign mis_cnt        = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_pipe.sv
module tb_branch_resolve_pipe;

    localparam int WIDTH   = 32;
    localparam int TAGW    = 8;
    localparam int CNTW    = 4;
    localparam int ENT_W   = TAGW + 2;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_rs;
    logic [WIDTH-1:0] in_rt;
    logic             in_pred;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_mispredict;
    logic [TAGW-1:0]  out_tag;
    logic             cnt_clr;
    logic [CNTW-1:0]  br_cnt;
    logic [CNTW-1:0]  mis_cnt;

    branch_resolve_pipe #(.WIDTH(WIDTH), .TAGW(TAGW), .CNTW(CNTW)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_rs          (in_rs),
        .in_rt          (in_rt),
        .in_pred        (in_pred),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_mispredict (out_mispredict),
        .out_tag        (out_tag),
        .cnt_clr        (cnt_clr),
        .br_cnt         (br_cnt),
        .mis_cnt        (mis_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [ENT_W-1:0] exp_q[$];        // accepted, not yet delivered {tag,taken,mis}
    int               exp_cyc_q[$];
    logic [ENT_W-1:0] exp_out_q[$];    // model entries in delivery order
    int               exp_out_cyc_q[$];
    logic [ENT_W-1:0] got_q[$];        // observed deliveries
    int               got_cyc_q[$];
    int               extra_out;
    int               br_m, mis_m;
    int               cyc;
    int               n_acc;
    bit               last_acc;
    int               n_cmp, n_bad;

    // Reference: branch rules expressed as plain arithmetic comparisons.
    function automatic logic ref_taken(input logic [2:0] op, input logic [WIDTH-1:0] rs,
                                       input logic [WIDTH-1:0] rt);
        case (op)
            3'd0:    return rs == rt;
            3'd1:    return rs != rt;
            3'd2:    return $signed(rs) < 0;
            3'd3:    return $signed(rs) <= 0;
            3'd4:    return $signed(rs) > 0;
            3'd5:    return $signed(rs) >= 0;
            3'd6:    return $signed(rs) < $signed(rt);
            default: return rs < rt;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: observe handshakes at the falling edge, update the model,
    // then return 1 time unit after the rising edge.
    task automatic step();
        logic [ENT_W-1:0] e;
        logic             t;
        @(negedge clk);
        cyc++;
        last_acc = in_valid && in_ready && !flush;
        if (out_valid && out_ready) begin
            got_q.push_back({out_tag, out_taken, out_mispredict});
            got_cyc_q.push_back(cyc);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_out_q.push_back(e);
                exp_out_cyc_q.push_back(exp_cyc_q.pop_front());
                if (br_m < CNT_MAX) br_m++;
                if (e[0] && mis_m < CNT_MAX) mis_m++;
            end else begin
                extra_out++;
            end
        end
        if (cnt_clr) begin
            br_m  = 0;
            mis_m = 0;
        end
        if (last_acc) begin
            t = ref_taken(in_op, in_rs, in_rt);
            exp_q.push_back({in_tag, t, t ^ in_pred});
            exp_cyc_q.push_back(cyc);
            n_acc++;
        end
        if (flush) begin
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] rs,
                         input logic [WIDTH-1:0] rt, input logic pred, input logic [TAGW-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_pred  = pred;
        in_tag   = tag;
    endtask

    task automatic drive_rand(input logic [TAGW-1:0] tag);
        drive(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
              1'($urandom_range(0, 1)), tag);
    endtask

    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] rs,
                        input logic [WIDTH-1:0] rt, input logic pred, input logic [TAGW-1:0] tag);
        drive(op, rs, rt, pred, tag);
        for (int k = 0; k < 50; k++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout tag=%0h: accepted=0 required=1", tag);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_obs();
        exp_out_q.delete();
        exp_out_cyc_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        extra_out = 0;
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid_rel: got %b want 0", out_valid); end
        n_cmp++; if (out_taken !== 1'b0) begin n_bad++; $display("FAIL rst_out_taken: got %b want 0", out_taken); end
        n_cmp++; if (out_mispredict !== 1'b0) begin n_bad++; $display("FAIL rst_out_mis: got %b want 0", out_mispredict); end
        n_cmp++; if (out_tag !== '0) begin n_bad++; $display("FAIL rst_out_tag: got %0h want 0", out_tag); end
        n_cmp++; if (br_cnt !== '0) begin n_bad++; $display("FAIL rst_br_cnt: got %0d want 0", br_cnt); end
        n_cmp++; if (mis_cnt !== '0) begin n_bad++; $display("FAIL rst_mis_cnt: got %0d want 0", mis_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [13:0]      tk;
        logic [13:0]      pv;
        logic [2:0]       op;
        logic [WIDTH-1:0] rs, rt;
        logic [ENT_W-1:0] want;
        tk = 14'b01_1010_0100_1110;
        pv = 14'($urandom);
        clear_obs();
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            op = (i < 8) ? 3'(i) : 3'(i - 6);
            rs = (i < 8) ? 32'hFFFF_FFFF : ((i < 12) ? 32'h0 : 32'h8000_0000);
            rt = (i < 8) ? 32'h1 : ((i < 12) ? 32'h0 : 32'h7FFF_FFFF);
            send(op, rs, rt, pv[i], TAGW'(i));
        end
        idle(4);
        n_cmp++;
        if (got_q.size() != 14) begin n_bad++; $display("FAIL dir_count: got %0d want 14", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 14; i++) begin
            want = {TAGW'(i), tk[i], tk[i] ^ pv[i]};
            n_cmp++;
            if (got_q[i] !== want) begin n_bad++; $display("FAIL dir_result[%0d]: got %0h want %0h", i, got_q[i], want); end
            n_cmp++;
            if (got_cyc_q[i] - exp_out_cyc_q[i] != 2) begin
                n_bad++; $display("FAIL dir_latency[%0d]: got %0d want 2", i, got_cyc_q[i] - exp_out_cyc_q[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (got_cyc_q[i] - got_cyc_q[i-1] != 1) begin
                    n_bad++; $display("FAIL dir_throughput[%0d]: gap %0d want 1", i, got_cyc_q[i] - got_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        clear_obs();
        n_acc     = 0;
        k         = 0;
        out_ready = 1'b0;
        drive_rand(8'h20);
        repeat (4) begin
            step();
            if (last_acc) begin
                k++;
                if (k < 5) drive_rand(TAGW'(8'h20 + k)); else in_valid = 1'b0;
            end
        end
        n_cmp++; if (n_acc != 2) begin n_bad++; $display("FAIL bp_accepted: got %0d want 2", n_acc); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_tag !== 8'h20) begin n_bad++; $display("FAIL bp_held_tag: got %0h want 20", out_tag); end
        if (exp_q.size() > 0) begin
            n_cmp++;
            if ({out_tag, out_taken, out_mispredict} !== exp_q[0]) begin
                n_bad++; $display("FAIL bp_held_result: got %0h want %0h", {out_tag, out_taken, out_mispredict}, exp_q[0]);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && k < 5; c++) begin
            step();
            if (last_acc) begin
                k++;
                if (k < 5) drive_rand(TAGW'(8'h20 + k)); else in_valid = 1'b0;
            end
        end
        idle(4);
        n_cmp++; if (got_q.size() != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            n_cmp++;
            if (got_q[i][ENT_W-1:2] !== TAGW'(8'h20 + i)) begin
                n_bad++; $display("FAIL bp_order[%0d]: got %0h want %0h", i, got_q[i][ENT_W-1:2], 8'h20 + i);
            end
            n_cmp++;
            if (got_q[i] !== exp_out_q[i]) begin
                n_bad++; $display("FAIL bp_result[%0d]: got %0h want %0h", i, got_q[i], exp_out_q[i]);
            end
        end
    endtask

    task automatic test_flush();
        pulse_clr();
        clear_obs();
        // Two in flight with the consumer stalled: nothing may be delivered.
        out_ready = 1'b0;
        send(3'd0, 32'h5, 32'h5, 1'b0, 8'h40);
        send(3'd1, 32'h5, 32'h5, 1'b1, 8'h41);
        flush = 1'b1;
        drive_rand(8'h42);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fl_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (br_cnt !== '0) begin n_bad++; $display("FAIL fl_br_cnt: got %0d want 0", br_cnt); end
        out_ready = 1'b1;
        idle(4);
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL fl_leak: got %0d outputs want 0", got_q.size()); end
        // Consumer ready: the result leaving in the flush cycle is still delivered.
        clear_obs();
        send(3'd0, 32'h7, 32'h7, 1'b0, 8'h50);
        send(3'd0, 32'h7, 32'h7, 1'b0, 8'h51);
        flush = 1'b1;
        drive_rand(8'h52);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (br_cnt !== 4'd1) begin n_bad++; $display("FAIL fl_deliver_cnt: got %0d want 1", br_cnt); end
        n_cmp++; if (mis_cnt !== 4'd1) begin n_bad++; $display("FAIL fl_deliver_mis: got %0d want 1", mis_cnt); end
        idle(4);
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL fl_deliver_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++;
            if (got_q[0] !== {8'h50, 1'b1, 1'b1}) begin
                n_bad++; $display("FAIL fl_deliver_result: got %0h want %0h", got_q[0], {8'h50, 1'b1, 1'b1});
            end
        end
    endtask

    task automatic test_saturation();
        logic [WIDTH-1:0] v;
        pulse_clr();
        clear_obs();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v = WIDTH'($urandom);
            send(3'd0, v, v, 1'b0, TAGW'(8'h60 + i));
        end
        idle(4);
        n_cmp++; if (br_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_br_cnt: got %0d want 15", br_cnt); end
        n_cmp++; if (mis_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_mis_cnt: got %0d want 15", mis_cnt); end
        n_cmp++; if (got_q.size() != 20) begin n_bad++; $display("FAIL sat_count: got %0d want 20", got_q.size()); end
        send(3'd7, 32'h1, 32'h2, 1'b0, 8'h77);
        idle(1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_setup_valid: got %b want 1", out_valid); end
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        n_cmp++; if (br_cnt !== '0) begin n_bad++; $display("FAIL clr_br_cnt: got %0d want 0", br_cnt); end
        n_cmp++; if (mis_cnt !== '0) begin n_bad++; $display("FAIL clr_mis_cnt: got %0d want 0", mis_cnt); end
    endtask

    task automatic test_random();
        logic [ENT_W-1:0] obs;
        clear_obs();
        in_valid = 1'b0;
        last_acc = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!in_valid || last_acc) begin
                if ($urandom_range(0, 3) != 0) drive_rand(TAGW'($urandom)); else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            cnt_clr   = ($urandom_range(0, 39) == 0);
            step();
            obs = {out_tag, out_taken, out_mispredict};
            if (out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_spurious c=%0d: got valid %0h want none", c, obs);
                end else if (obs !== exp_q[0]) begin
                    n_bad++; $display("FAIL rnd_head c=%0d: got %0h want %0h", c, obs, exp_q[0]);
                end
            end
            n_cmp++;
            if (br_cnt !== CNTW'(br_m) || mis_cnt !== CNTW'(mis_m)) begin
                n_bad++; $display("FAIL rnd_counters c=%0d: got %0d/%0d want %0d/%0d", c, br_cnt, mis_cnt, br_m, mis_m);
            end
        end
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        idle(4);
        n_cmp++;
        if (got_q.size() != exp_out_q.size() || extra_out != 0) begin
            n_bad++; $display("FAIL rnd_count: got %0d (extra %0d) want %0d", got_q.size(), extra_out, exp_out_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_out_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_out_q[i]) begin
                n_bad++; $display("FAIL rnd_result[%0d]: got %0h want %0h", i, got_q[i], exp_out_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_clr();
        clear_obs();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(3'd1, 32'h1, 32'h2, 1'b0, TAGW'(8'h80 + i));
        idle(3);
        out_ready = 1'b0;
        send(3'd6, 32'hFFFF_FFFF, 32'h1, 1'b0, 8'h90);
        send(3'd0, 32'h3, 32'h4, 1'b1, 8'h91);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rm_setup_valid: got %b want 1", out_valid); end
        n_cmp++; if (br_cnt !== 4'd3) begin n_bad++; $display("FAIL rm_setup_cnt: got %0d want 3", br_cnt); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_taken !== 1'b0 || out_mispredict !== 1'b0) begin
            n_bad++; $display("FAIL rm_out_bits: got %b%b want 00", out_taken, out_mispredict);
        end
        n_cmp++; if (out_tag !== '0) begin n_bad++; $display("FAIL rm_out_tag: got %0h want 0", out_tag); end
        n_cmp++; if (br_cnt !== '0 || mis_cnt !== '0) begin
            n_bad++; $display("FAIL rm_counters: got %0d/%0d want 0/0", br_cnt, mis_cnt);
        end
        in_valid = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        br_m  = 0;
        mis_m = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_obs();
        out_ready = 1'b1;
        send(3'd5, 32'h0, 32'h0, 1'b0, 8'h99);
        idle(4);
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL rm_after_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++;
            if (got_q[0] !== {8'h99, 1'b1, 1'b1}) begin
                n_bad++; $display("FAIL rm_after_result: got %0h want %0h", got_q[0], {8'h99, 1'b1, 1'b1});
            end
            n_cmp++;
            if (got_cyc_q[0] - exp_out_cyc_q[0] != 2) begin
                n_bad++; $display("FAIL rm_after_latency: got %0d want 2", got_cyc_q[0] - exp_out_cyc_q[0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        n_acc     = 0;
        br_m      = 0;
        mis_m     = 0;
        extra_out = 0;
        last_acc  = 1'b0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_pred   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
